// File: rtl/vga_timing.sv
// vga_timing: programmable raster timing generator (sync, data enable, coordinates).
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_o counter.
module vga_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        sof_o,
  output logic        eol_o
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_o
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly
  localparam logic [12:0] HA  = 13'(H_ACTIVE);
  localparam logic [12:0] HS0 = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS1 = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VA  = 13'(V_ACTIVE);
  localparam logic [12:0] VS0 = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS1 = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] HL  = 12'(H_TOTAL - 1);
  localparam logic [11:0] VL  = 12'(V_TOTAL - 1);
  localparam logic [11:0] HE  = 12'(H_ACTIVE - 1);
  logic [11:0] h, v, h_nxt, v_nxt;
  logic [12:0] hx, vx;
  logic        h_last, v_last;
  assign hx = {1'b0, h};
  assign vx = {1'b0, v};
  always_comb begin
    h_last = h == HL;
    v_last = v == VL;
    h_nxt  = h_last ? '0 : h + 12'd1;
    v_nxt  = h_last ? (v_last ? '0 : v + 12'd1) : v;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h     <= '0;
      v     <= '0;
      hs_o  <= ~HS_POL;
      vs_o  <= ~VS_POL;
      de_o  <= 1'b0;
      x_o   <= '0;
      y_o   <= '0;
      sof_o <= 1'b0;
      eol_o <= 1'b0;
    end else if (en) begin
      h     <= h_nxt;
      v     <= v_nxt;
      hs_o  <= (hx >= HS0 && hx < HS1) ? HS_POL : ~HS_POL;
      vs_o  <= (vx >= VS0 && vx < VS1) ? VS_POL : ~VS_POL;
      de_o  <= hx < HA && vx < VA;
      x_o   <= h;
      y_o   <= v;
      sof_o <= h == '0 && v == '0;
      eol_o <= h == HE && vx < VA;
    end
  end
`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_o <= '0;
    else if (en && h_last && v_last) frame_o <= frame_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing on a small 15x8 raster.
module tb_vga_timing;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic        hs_o, vs_o, de_o, sof_o, eol_o;
  logic [11:0] x_o, y_o;
  logic [15:0] frame_o;
  always #5 clk = ~clk;
  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o),
    .x_o(x_o), .y_o(y_o), .sof_o(sof_o), .eol_o(eol_o)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_o(frame_o)
`endif
  );
`ifndef VGA_TIMING_FRAME_CNT_EN
  assign frame_o = '0;
`endif
  typedef struct {
    logic [28:0] o;
    logic [15:0] f;
  } exp_t;
  localparam logic [28:0] RST_V = {1'b0, 1'b1, 3'b000, 24'd0};
  logic [28:0] act;
  assign act = {hs_o, vs_o, de_o, sof_o, eol_o, x_o, y_o};
  exp_t q[$];
  exp_t last;
  int   sof_t[$];
  int   checks = 0, errors = 0, cyc = 0, vs_cnt = 0, eol_cnt = 0;
  int   mh = 0, mv = 0;
  logic [15:0] mf = '0;
  // H_TOTAL 15: hsync h 10..12 (active-high); V_TOTAL 8: vsync v 5..6 (active-low)
  function automatic logic [28:0] model(int h, int v);
    return {(h >= 10 && h < 13) ? 1'b1 : 1'b0, (v >= 5 && v < 7) ? 1'b0 : 1'b1,
            (h < 8 && v < 4), (h == 0 && v == 0), (h == 7 && v < 4), 12'(h), 12'(v)};
  endfunction
  task automatic check(string name, logic [28:0] a, logic [28:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got hs,vs,de,sof,eol,x,y=%h expected %h", name, a, e);
    end
  endtask
  task automatic check_int(string name, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask
  task automatic step(logic e);
    exp_t t;
    @(negedge clk);
    en = e;
    if (e) begin
      t.o = model(mh, mv);
      if (mh == 14) begin
        mh = 0;
        if (mv == 7) begin
          mv = 0;
          mf = mf + 16'd1;
        end else mv++;
      end else mh++;
      t.f = mf;
      q.push_back(t);
    end
  endtask
  always @(posedge clk) begin
    logic e;
    cyc++;
    e = en;
    if (!rst) begin
      #1;
      if (!e) check("hold", act, last.o);
      else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got an enabled edge expected a queued entry");
      end else begin
        last = q.pop_front();
        check("out", act, last.o);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check_int("frame", int'(frame_o), int'(last.f));
`endif
        if (sof_o) sof_t.push_back(cyc);
        if (!vs_o) vs_cnt++;
        if (eol_o) eol_cnt++;
      end
    end
  end
  initial begin
    last.o = RST_V;
    last.f = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("reset", act, RST_V);
    repeat (260) step(1'b1);
    step(1'b0);
    check_int("sof_count_cont", sof_t.size(), 3);
    if (sof_t.size() >= 2) check_int("sof_period_cont", sof_t[1] - sof_t[0], 120);
    check_int("vsync_len", vs_cnt, 60);
    check_int("eol_count", eol_cnt, 9);
    sof_t.delete();
    repeat (250) begin
      step(1'b1);
      step(1'b0);
    end
    check_int("sof_count_toggle", sof_t.size(), 2);
    if (sof_t.size() >= 2) check_int("sof_period_toggle", sof_t[1] - sof_t[0], 240);
    for (int i = 0; i < 200 && !(mh == 6 && mv == 2); i++) step(1'b1);
    @(posedge clk);
    #3;
    check_int("pre_reset_xy", {x_o, y_o}, {12'd5, 12'd2});
    rst = 1'b1;
    en  = 1'b0;
    #1 check("rst_mid", act, RST_V);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mh = 0;
    mv = 0;
    mf = '0;
    last.o = RST_V;
    last.f = '0;
    sof_t.delete();
    repeat (365) step(1'b1);
    step(1'b0);
    check_int("sof_count_after_rst", sof_t.size(), 4);
    check_int("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
